// File: rtl/draw_arbiter_pkg.sv
// Shared constants for the breakout drawing path.
//   Drawer indices into the req/done/grant vectors, screen size, 3-bit
//   colour codes and the arbiter FSM state type.
package draw_arbiter_pkg;

  localparam int NUM_DRAWERS   = 3;
  localparam int DRAWER_PLAT   = 0;
  localparam int DRAWER_BALL   = 1;
  localparam int DRAWER_BRICK  = 2;

  localparam int SCREEN_W      = 160;
  localparam int SCREEN_H      = 120;

  localparam logic [2:0] COL_BLACK   = 3'b000;
  localparam logic [2:0] COL_BLUE    = 3'b001;
  localparam logic [2:0] COL_GREEN   = 3'b010;
  localparam logic [2:0] COL_CYAN    = 3'b011;
  localparam logic [2:0] COL_RED     = 3'b100;
  localparam logic [2:0] COL_MAGENTA = 3'b101;
  localparam logic [2:0] COL_YELLOW  = 3'b110;
  localparam logic [2:0] COL_WHITE   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/draw_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req_i   : request vector
//   ptr_i   : index that has first priority; priority then rotates upward
//             and wraps to 0
//   pick_o  : one-hot selection, 0 when nothing requests
//   valid_o : at least one request present
// Kept free of state so the brick-cell scanner can reuse it.
module rr_picker
  import draw_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_DRAWERS,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic               valid_o
);

  logic found;
  int   idx;

  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr_i is always < NUM_REQ, so one subtraction is enough to wrap.
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        found       = 1'b1;
      end
    end
    valid_o = |req_i;
  end

endmodule

// File: rtl/draw_arbiter.sv
// Pixel-bus arbiter between the sprite drawers and the VGA adapter.
//   clk, resetn          : clock, synchronous active-low reset
//   req, done            : per-drawer request level / finished pulse
//   x_in, y_in, colour_in, wren_in : flattened per-drawer pixel buses
//   grant                : registered one-hot grant (drawer's draw strobe)
//   tick                 : one-cycle frame pulse every FRAME_DIV cycles
//   vga_x, vga_y, vga_colour, vga_wren : bus of the granted drawer
//   timeout              : sticky, a grant was revoked by the watchdog
//
// state    | meaning
// IDLE     | no grant; arbitrate among requests
// GRANT    | one drawer owns the bus; watchdog running
// RELEASE  | grant forced low for one cycle; pointer already advanced,
//          | next winner is picked here so the gap is exactly one cycle
module draw_arbiter
  import draw_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = NUM_DRAWERS,
  parameter int FRAME_DIV = 833333,
  parameter int MAX_GRANT = 32768
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    done,
  input  logic [10*NUM_REQ-1:0] x_in,
  input  logic [10*NUM_REQ-1:0] y_in,
  input  logic [3*NUM_REQ-1:0]  colour_in,
  input  logic [NUM_REQ-1:0]    wren_in,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  tick,
  output logic [9:0]            vga_x,
  output logic [9:0]            vga_y,
  output logic [2:0]            vga_colour,
  output logic                  vga_wren,
  output logic                  timeout
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int FCNT_W = $clog2(FRAME_DIV);
  localparam int WDOG_W = $clog2(MAX_GRANT) + 1;

  localparam logic [FCNT_W-1:0] FRAME_RELOAD = FCNT_W'(FRAME_DIV - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST    = WDOG_W'(MAX_GRANT - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST     = PTR_W'(NUM_REQ - 1);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                timeout_q, timeout_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;

  logic [NUM_REQ-1:0]  pick;
  logic                pick_valid;
  logic [PTR_W-1:0]    gidx;
  logic [PTR_W-1:0]    ptr_next;
  logic                grantee_done;

  // Frame tick: free-running down-counter, independent of arbitration.
  assign tick   = (fcnt_q == '0);
  assign fcnt_d = tick ? FRAME_RELOAD : fcnt_q - 1'b1;

  always_ff @(posedge clk) begin
    if (!resetn) fcnt_q <= FRAME_RELOAD;
    else         fcnt_q <= fcnt_d;
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .pick_o  (pick),
    .valid_o (pick_valid)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) gidx = PTR_W'(i);
    end
    ptr_next = (gidx == PTR_LAST) ? '0 : gidx + 1'b1;
  end

  // done from anyone but the current grantee is masked off here.
  assign grantee_done = |(done & grant_q);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE, ST_RELEASE: begin
        if (pick_valid) begin
          grant_d = pick;
          wdog_d  = '0;
          state_d = ST_GRANT;
        end else begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (grantee_done) begin
          grant_d = '0;
          ptr_d   = ptr_next;
          state_d = ST_RELEASE;
        end else if (wdog_q == WDOG_LAST) begin
          grant_d   = '0;
          ptr_d     = ptr_next;
          timeout_d = 1'b1;
          state_d   = ST_RELEASE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  // Grant is one-hot, so OR-ing the masked buses acts as the mux and
  // naturally yields 0 when nothing is granted.
  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        vga_x      = vga_x      | x_in[10*i +: 10];
        vga_y      = vga_y      | y_in[10*i +: 10];
        vga_colour = vga_colour | colour_in[3*i +: 3];
      end
    end
  end

  assign vga_wren = |(wren_in & grant_q);
  assign grant    = grant_q;
  assign timeout  = timeout_q;

endmodule
